// File: rtl/p12_cfg_loader_if.sv
// rtl/p12_cfg_loader_if.sv - host command and readback bundle for the p12 configuration loader
interface p12_cfg_loader_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rd_valid;
    logic [7:0] rd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/p12_cfg_loader.sv
// rtl/p12_cfg_loader.sv - scan-chain shifter and v/h/d latch strobe sequencer for the p12 tile array
module p12_cfg_loader #(
    parameter int unsigned STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    p12_cfg_loader_if.slave   io_host,
    input  logic              i_run_en,
    output logic              o_sc_en,
    output logic              o_sc_out,
    input  logic              i_sc_in,
    output logic              o_clk_en,
    output logic              o_lat_v,
    output logic              o_lat_h,
    output logic              o_lat_d,
    output logic              o_lb,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_PRE,
        S_STROBE,
        S_POST
    } state_t;

    localparam logic [3:0] STRB_LAST = 4'(STROBE_CYC - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_op;
    logic [7:0] r_data;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_strb_cnt;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;
    logic       r_lat_v;
    logic       r_lat_h;
    logic       r_lat_d;

    logic       w_accept;
    logic       w_cmd_ready;
    logic       w_sc_en;
    logic       w_sc_out;
    logic       w_clk_en;
    logic       w_lb;

    assign w_accept = io_host.cmd_valid && (r_state == S_IDLE);

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_sc_en     = 1'b0;
        w_sc_out    = 1'b0;
        w_clk_en    = 1'b0;
        w_lb        = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                w_clk_en    = i_run_en;
                w_lb        = ~i_run_en;
                if (w_accept) begin
                    w_next = (io_host.cmd_op == 2'd0) ? S_SHIFT : S_PRE;
                end
            end
            S_SHIFT: begin
                w_sc_en  = 1'b1;
                w_sc_out = r_data[r_bit_cnt];
                w_clk_en = 1'b1;
                if (r_bit_cnt == 3'd7) begin
                    w_next = S_IDLE;
                end
            end
            S_PRE:    w_next = S_STROBE;
            S_STROBE: begin
                if (r_strb_cnt == STRB_LAST) begin
                    w_next = S_POST;
                end
            end
            S_POST:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= 2'd0;
            r_data     <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_strb_cnt <= 4'd0;
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
            r_lat_v    <= 1'b0;
            r_lat_h    <= 1'b0;
            r_lat_d    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= (r_state == S_SHIFT) && (r_bit_cnt == 3'd7);
            if (w_accept) begin
                r_op       <= io_host.cmd_op;
                r_data     <= io_host.cmd_data;
                r_bit_cnt  <= 3'd0;
                r_strb_cnt <= 4'd0;
            end
            if (r_state == S_SHIFT) begin
                r_rd_data[r_bit_cnt] <= i_sc_in;
                r_bit_cnt            <= r_bit_cnt + 3'd1;
            end
            if (r_state == S_STROBE) begin
                r_strb_cnt <= r_strb_cnt + 4'd1;
            end
            // Strobes are registered from the next state so they open one cycle after PRE freezes the chain
            r_lat_v <= (w_next == S_STROBE) && (r_op == 2'd1);
            r_lat_h <= (w_next == S_STROBE) && (r_op == 2'd2);
            r_lat_d <= (w_next == S_STROBE) && (r_op == 2'd3);
        end
    end

    assign io_host.cmd_ready = w_cmd_ready;
    assign io_host.rd_valid  = r_rd_valid;
    assign io_host.rd_data   = r_rd_data;
    assign o_sc_en           = w_sc_en;
    assign o_sc_out          = w_sc_out;
    assign o_clk_en          = w_clk_en;
    assign o_lb              = w_lb;
    assign o_lat_v           = r_lat_v;
    assign o_lat_h           = r_lat_h;
    assign o_lat_d           = r_lat_d;
    assign o_busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_p12_cfg_loader.sv
// tb/tb_p12_cfg_loader.sv - table-driven bench for p12_cfg_loader with an 8-bit chain and tile latch model
module tb_p12_cfg_loader;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_run_en = 1'b0;
    logic o_sc_en, o_sc_out, o_clk_en, o_lat_v, o_lat_h, o_lat_d, o_lb, o_busy;
    logic w_sc_in;

    p12_cfg_loader_if host ();

    p12_cfg_loader #(.STROBE_CYC(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_host  (host.slave),
        .i_run_en (i_run_en),
        .o_sc_en  (o_sc_en),
        .o_sc_out (o_sc_out),
        .i_sc_in  (w_sc_in),
        .o_clk_en (o_clk_en),
        .o_lat_v  (o_lat_v),
        .o_lat_h  (o_lat_h),
        .o_lat_d  (o_lat_d),
        .o_lb     (o_lb),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    // Four tiles of two scan bits each; the tail feeds sc_in
    logic [7:0] r_chain;
    logic [7:0] r_tv, r_th, r_td;
    assign w_sc_in = r_chain[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chain <= 8'd0;
        else if (o_clk_en && o_sc_en) r_chain <= {r_chain[6:0], o_sc_out};
    end

    always_ff @(posedge clk) begin
        if (o_lat_v) r_tv <= r_chain;
        if (o_lat_h) r_th <= r_chain;
        if (o_lat_d) r_td <= r_chain;
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic       run_en;
        int         exp_len;
        logic [2:0] exp_lat;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] exp_q[$];
    logic [7:0] prev_data;
    logic [7:0] last_rd;
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic logic [7:0] bitrev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n && host.rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
                last_rd = exp_q.pop_front();
                chk("rd_data", {24'd0, host.rd_data}, {24'd0, last_rd});
            end
        end
    endtask

    function automatic logic [8:0] outs();
        return {host.cmd_ready, o_busy, o_sc_en, o_sc_out, o_clk_en, o_lb, o_lat_v, o_lat_h, o_lat_d};
    endfunction

    task automatic chk_idle(input string name);
        chk(name, {23'd0, outs()}, {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, i_run_en, ~i_run_en, 3'b000});
    endtask

    task automatic run_cmd(input vec_t v);
        int c;
        logic [8:0] e;
        i_run_en = v.run_en;
        #1;
        chk_idle("idle_before");
        host.cmd_valid = 1'b1;
        host.cmd_op    = v.op;
        host.cmd_data  = v.data;
        if (v.op == 2'd0) begin
            exp_q.push_back(prev_data);
        end
        tick();
        host.cmd_valid = 1'b0;
        c = 1;
        while (o_busy && c <= 20) begin
            if (v.op == 2'd0) begin
                e = {1'b0, 1'b1, 1'b1, v.data[c-1], 1'b1, 1'b1, 3'b000};
            end else begin
                e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                     ((c >= 2 && c <= 1 + S) ? v.exp_lat : 3'b000)};
                chk("chain_frozen", {24'd0, r_chain}, {24'd0, bitrev(prev_data)});
            end
            chk($sformatf("cyc%0d_op%0d", c, v.op), {23'd0, outs()}, {23'd0, e});
            if (c == 3) i_run_en = ~i_run_en;
            tick();
            c++;
        end
        chk("busy_len", c - 1, v.exp_len);
        chk("rd_valid_at_idle", {31'd0, host.rd_valid}, {31'd0, (v.op == 2'd0)});
        chk_idle("idle_after");
        if (v.op == 2'd0) begin
            prev_data = v.data;
        end else begin
            chk("rd_hold", {24'd0, host.rd_data}, {24'd0, last_rd});
            case (v.op)
                2'd1:    chk("tile_v", {24'd0, r_tv}, {24'd0, bitrev(prev_data)});
                2'd2:    chk("tile_h", {24'd0, r_th}, {24'd0, bitrev(prev_data)});
                default: chk("tile_d", {24'd0, r_td}, {24'd0, bitrev(prev_data)});
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [17:0] busy_seen;
        vecs[0] = '{2'd0, 8'hA5, 1'b0, 8,     3'b000};
        vecs[1] = '{2'd0, 8'h3C, 1'b0, 8,     3'b000};
        vecs[2] = '{2'd2, 8'h00, 1'b0, 2 + S, 3'b010};
        vecs[3] = '{2'd1, 8'hFF, 1'b1, 2 + S, 3'b100};
        vecs[4] = '{2'd3, 8'h00, 1'b0, 2 + S, 3'b001};
        vecs[5] = '{2'd0, 8'hFF, 1'b1, 8,     3'b000};
        vecs[6] = '{2'd0, 8'h00, 1'b1, 8,     3'b000};
        vecs[7] = '{2'd1, 8'h00, 1'b0, 2 + S, 3'b100};
        vecs[8] = '{2'd0, 8'h81, 1'b0, 8,     3'b000};
        vecs[9] = '{2'd3, 8'h55, 1'b1, 2 + S, 3'b001};

        host.cmd_valid = 1'b0;
        host.cmd_op    = 2'd0;
        host.cmd_data  = 8'd0;
        prev_data      = 8'd0;
        last_rd        = 8'd0;

        i_run_en = 1'b1;
        #1;
        chk("reset_run1", {23'd0, outs()}, {23'd0, 9'b1_0_0_0_1_0_000});
        i_run_en = 1'b0;
        #1;
        chk("reset_run0", {23'd0, outs()}, {23'd0, 9'b1_0_0_0_0_1_000});
        chk("reset_rd", {23'd0, host.rd_valid, host.rd_data}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

        // Reset during the second strobe cycle of LATCH_V
        host.cmd_valid = 1'b1;
        host.cmd_op    = 2'd1;
        tick();
        host.cmd_valid = 1'b0;
        tick();
        tick();
        chk("strobe2_lat_v", {31'd0, o_lat_v}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_drop", {23'd0, outs()}, {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, i_run_en, ~i_run_en, 3'b000});
        tick();
        rst_n = 1'b1;
        prev_data = 8'd0;
        last_rd   = 8'd0;
        tick();
        chk("post_reset_rd", {23'd0, host.rd_valid, host.rd_data}, 32'd0);

        // Reset in the middle of a SHIFT: no readback may follow
        host.cmd_valid = 1'b1;
        host.cmd_op    = 2'd0;
        host.cmd_data  = 8'h5A;
        tick();
        host.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_shift_sc_en", {31'd0, o_sc_en}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("abort_no_rd", {24'd0, host.rd_data}, 32'd0);

        // SHIFT held valid back to back: IDLE acceptance cycle sits between the two
        host.cmd_valid = 1'b1;
        host.cmd_op    = 2'd0;
        host.cmd_data  = 8'hC3;
        exp_q.push_back(prev_data);
        exp_q.push_back(8'hC3);
        prev_data = 8'hC3;
        for (int c = 1; c <= 18; c++) begin
            tick();
            busy_seen[c-1] = o_busy;
            if (c == 10) host.cmd_valid = 1'b0;
        end
        chk("b2b_busy", {14'd0, busy_seen}, {14'd0, 18'b01_1111_1110_1111_1111});
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
